retospect_config_loader: RTL and testbench
==========================================

Name: retospect_config_loader

Overview:
- Sequences the neurochip configuration scan chain (clockbox `clock_max` registers followed by the CNB weight/threshold/decay registers).
- Accepts configuration bytes from the host over a valid/ready byte interface and serializes them LSB-first onto the chain. It drives `config_en` for exactly CHAIN_LEN shift cycles, then issues a one-cycle `reset_nn` pulse to restart neuron state.
- Computes a CRC-8 over the old configuration bits that fall out of the chain end, so the host can read back the previous configuration.
- Sits between the pad-level byte interface and the chain in the top level.

Parameters:
- CHAIN_LEN, 67: total scan-chain length in bits (48 clockbox + 19 per CNB × 1 CNB); must be ≥ 1.
- CNT_W, 8: width of the total-bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a load; honoured only in IDLE
- abort  input  1  synchronous abort; returns to IDLE from any state
- byte_data  input  8  configuration byte; bit 0 is shifted first
- byte_valid  input  1  byte_data is valid
- byte_ready  output  1  loader can accept a byte this cycle
- config_en  output  1  chain shift enable
- bs_out  output  1  serial bit into the chain head
- chain_in  input  1  serial bit from the chain tail (last element's bs_out)
- reset_nn  output  1  one-cycle neuron-state reset pulse
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on successful completion
- crc  output  8  CRC-8 of bits shifted out of chain_in during the last load

Behaviour:
- All outputs are registered. Reset values:
  - byte_ready, config_en, bs_out, reset_nn, busy, done = 0
  - crc = 0x00
  - state = IDLE; all counters and shift registers = 0.
- Counters:
  - bit_cnt (3 bits): position within the current byte.
  - total_cnt (CNT_W bits): bits shifted so far in this load.
- IDLE:
  - start=1 → WAIT_BYTE next cycle; total_cnt and crc cleared; busy=1.
  - start while not IDLE is ignored.
- WAIT_BYTE:
  - byte_ready=1 and config_en=0; the chain holds its contents.
  - When byte_valid & byte_ready: byte_data is latched into shreg, bit_cnt=0, next state is SHIFT, and byte_ready drops the following cycle.
- SHIFT (one bit per cycle):
  - config_en=1 and bs_out=shreg[0] are presented together.
  - Each cycle: shreg shifts right, bit_cnt++ and total_cnt++.
  - crc updates with chain_in sampled in the same cycle: fb = crc[7] ^ chain_in; crc = {crc[6:0],0} ^ (fb ? 0x07 : 0x00).
- Leaving SHIFT:
  - total_cnt reaches CHAIN_LEN → NN_RST. Any remaining bits of the final byte are discarded, so with CHAIN_LEN=67 only bits [2:0] of byte 9 are used.
  - Otherwise, bit_cnt wraps to 0 after 8 bits → WAIT_BYTE.
- NN_RST: reset_nn=1 for exactly one cycle, config_en=0 → DONE.
- DONE: done=1 for one cycle; crc is final and held until the next start → IDLE.
- Latency:
  - A byte accepted at edge t produces config_en=1 on cycles t+1 … t+k, where k = min(8, CHAIN_LEN − bits already shifted).
  - Back-to-back bytes give at least one config_en=0 cycle between them (the WAIT_BYTE handshake cycle).
- Invariant: config_en is high for exactly CHAIN_LEN cycles per completed load.
- abort:
  - Takes priority over every other input.
  - Next cycle: IDLE, config_en/byte_ready/reset_nn=0, no done, crc held at its partial value.
  - Partial chain contents are left as-is.
- byte_valid in IDLE, SHIFT, NN_RST or DONE is ignored; no byte is consumed.
- Reset asserted mid-load: all outputs go to reset values immediately (asynchronous); no reset_nn pulse is issued.
- start and abort together in IDLE: abort wins and the block stays in IDLE.

Test Plan:
- Full load, CHAIN_LEN=67, bytes 0x01..0x09 with byte_valid held high:
  - 9 handshakes, config_en high for 67 cycles total.
  - The bs_out sequence equals the LSB-first bits of the bytes, truncated after 3 bits of 0x09.
  - reset_nn pulses once, then done pulses once, then busy=0.
- Readback CRC:
  - Preload the chain with all-ones, then load all-zeros; crc equals CRC-8/0x07 of 67 ones (compute from the reference model).
  - A second all-zero load gives crc=0x00.
- Host stall: byte_valid dropped for 5 cycles between bytes 3 and 4 → config_en=0 and the chain holds through the stall; final chain contents are unchanged versus the no-stall run.
- Abort at total_cnt=20 → IDLE next cycle; no reset_nn, no done; a subsequent start performs a clean full load.
- CHAIN_LEN=8, single byte 0xA5 → exactly 8 config_en cycles with bs_out = 1,0,1,0,0,1,0,1, then reset_nn, then done.
- Async rst_n low during SHIFT → all outputs 0 in the same cycle; start is ignored while rst_n=0.

Source files
------------

// File: rtl/retospect_config_loader.sv
// Configuration scan-chain loader: takes host bytes over valid/ready, shifts them LSB-first
// into the chain, then pulses reset_nn and done. crc covers the old bits leaving the chain tail.
module retospect_config_loader #(
    parameter int CHAIN_LEN = 67,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       config_en,
    output logic       bs_out,
    input  logic       chain_in,
    output logic       reset_nn,
    output logic       busy,
    output logic       done,
    output logic [7:0] crc
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_NNRST = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    logic [2:0]       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] total_cnt_q, total_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       crc_q, crc_d;
    logic             byte_ready_q, byte_ready_d;
    logic             config_en_q, config_en_d;
    logic             reset_nn_q, reset_nn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // CRC-8, polynomial x^8 + x^2 + x + 1, one serial bit per call
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        total_cnt_d  = total_cnt_q;
        shreg_d      = shreg_q;
        crc_d        = crc_q;
        byte_ready_d = byte_ready_q;
        config_en_d  = config_en_q;
        reset_nn_d   = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_WAIT;
                    total_cnt_d  = '0;
                    crc_d        = 8'h00;
                    byte_ready_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (byte_valid && byte_ready_q) begin
                    shreg_d      = byte_data;
                    bit_cnt_d    = 3'd0;
                    state_d      = S_SHIFT;
                    byte_ready_d = 1'b0;
                    config_en_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                shreg_d     = {1'b0, shreg_q[7:1]};
                bit_cnt_d   = bit_cnt_q + 3'd1;
                total_cnt_d = total_cnt_q + CNT_W'(1);
                crc_d       = crc8_step(crc_q, chain_in);
                // Chain-full check wins over byte wrap, discarding the tail of the last byte
                if (total_cnt_q == LAST_CNT) begin
                    state_d     = S_NNRST;
                    config_en_d = 1'b0;
                    reset_nn_d  = 1'b1;
                end else if (bit_cnt_q == 3'd7) begin
                    state_d      = S_WAIT;
                    config_en_d  = 1'b0;
                    byte_ready_d = 1'b1;
                end
            end
            S_NNRST: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort freezes crc and counters at their partial values
        if (abort) begin
            state_d      = S_IDLE;
            bit_cnt_d    = bit_cnt_q;
            total_cnt_d  = total_cnt_q;
            shreg_d      = shreg_q;
            crc_d        = crc_q;
            byte_ready_d = 1'b0;
            config_en_d  = 1'b0;
            reset_nn_d   = 1'b0;
            done_d       = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            total_cnt_q  <= '0;
            shreg_q      <= '0;
            crc_q        <= '0;
            byte_ready_q <= 1'b0;
            config_en_q  <= 1'b0;
            reset_nn_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            total_cnt_q  <= total_cnt_d;
            shreg_q      <= shreg_d;
            crc_q        <= crc_d;
            byte_ready_q <= byte_ready_d;
            config_en_q  <= config_en_d;
            reset_nn_q   <= reset_nn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign config_en  = config_en_q;
    assign bs_out     = shreg_q[0];
    assign reset_nn   = reset_nn_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign crc        = crc_q;

endmodule

// File: tb/tb_retospect_config_loader.sv
// Bench for retospect_config_loader: emulated scan chains on both a 67-bit and an 8-bit
// instance, compared against a FIFO-style chain model and a serial CRC-8 reference.
module tb_retospect_config_loader;
    localparam int L = 67;

    logic       clk = 1'b0;
    logic       rst_n, start, start8, abort, byte_valid;
    logic [7:0] byte_data;
    logic       chain_in, chain_in8;
    logic       byte_ready, config_en, bs_out, reset_nn, busy, done;
    logic [7:0] crc;
    logic       byte_ready8, config_en8, bs_out8, reset_nn8, busy8, done8;
    logic [7:0] crc8;

    logic [L-1:0] chain  = '1;
    logic [7:0]   chain8 = 8'h00;
    logic [L-1:0] saved;

    int   checks   = 0;
    int   failures = 0;
    bit   mq[$];
    bit   mknown = 1'b1;
    logic [7:0] lb [16];

    retospect_config_loader #(.CHAIN_LEN(L), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .config_en(config_en), .bs_out(bs_out), .chain_in(chain_in),
        .reset_nn(reset_nn), .busy(busy), .done(done), .crc(crc)
    );

    retospect_config_loader #(.CHAIN_LEN(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready8),
        .config_en(config_en8), .bs_out(bs_out8), .chain_in(chain_in8),
        .reset_nn(reset_nn8), .busy(busy8), .done(done8), .crc(crc8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (config_en)  chain  <= {chain[L-2:0], bs_out};
    always @(posedge clk) if (config_en8) chain8 <= {chain8[6:0], bs_out8};
    assign chain_in  = chain[L-1];
    assign chain_in8 = chain8[7];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc_upd(input logic [7:0] c, input bit b);
        return (c[7] ^ b) ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    endfunction

    task automatic run_load(input int nbytes, input int stall_after, input int abort_at,
                            input int reset_at);
        int idx, stall, en_cnt, rnn_cnt, dn_cnt, hs_cnt, rnn_cyc, dn_cyc, overlap, lat_bad, quiet;
        bit hs, fin, ended_done, aborted, reset_hit, ob;
        logic [127:0] bs_vec, exp_vec, mask, mvec;
        logic [7:0]   mcrc;
        idx = 0; stall = 0; en_cnt = 0; rnn_cnt = 0; dn_cnt = 0; hs_cnt = 0;
        rnn_cyc = -1; dn_cyc = -2; overlap = 0; lat_bad = 0; quiet = 0;
        hs = 1'b0; fin = 1'b0; ended_done = 1'b0; aborted = 1'b0; reset_hit = 1'b0;
        bs_vec = '0; exp_vec = '0; mvec = '0; mcrc = 8'h00;
        for (int i = 0; i < L; i++) exp_vec[i] = lb[i/8][i%8];

        byte_valid = 1'($urandom_range(0, 1));
        byte_data  = 8'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 128'(busy), 128'(1));
        chk("start_ready", 128'(byte_ready), 128'(1));

        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (config_en) begin
                if (en_cnt < 128) bs_vec[en_cnt] = bs_out;
                en_cnt++;
            end
            if (reset_nn) begin rnn_cnt++; rnn_cyc = cyc; end
            if (done) begin dn_cnt++; dn_cyc = cyc; fin = 1'b1; ended_done = 1'b1; end
            if (config_en && byte_ready) overlap++;
            if (reset_at > 0 && config_en && en_cnt == reset_at) begin
                #2 rst_n = 1'b0;
                start = 1'b1;
                #1 chk("arst_outputs",
                       128'({byte_ready, config_en, bs_out, reset_nn, busy, done, crc}), '0);
                @(posedge clk);
                #1 chk("arst_start_ignored", 128'({busy, byte_ready, config_en}), '0);
                @(negedge clk);
                start = 1'b0;
                rst_n = 1'b1;
                fin = 1'b1;
                reset_hit = 1'b1;
            end else begin
                abort = (abort_at > 0 && config_en && en_cnt == abort_at);
                if (abort) begin fin = 1'b1; aborted = 1'b1; end
                start = 1'($urandom_range(0, 1));
                if (!byte_ready) begin
                    byte_valid = 1'($urandom_range(0, 1));
                    byte_data  = 8'($urandom);
                end else if (idx < nbytes && stall == 0) begin
                    byte_valid = 1'b1;
                    byte_data  = lb[idx];
                end else begin
                    byte_valid = 1'b0;
                    if (stall > 0) stall--;
                end
                hs = byte_valid && byte_ready && !abort;
                @(negedge clk);
                if (hs) begin
                    idx++; hs_cnt++;
                    if (!config_en) lat_bad++;
                    if (idx == stall_after) stall = 5;
                end
            end
        end
        start = 1'b0; abort = 1'b0; byte_valid = 1'b0;

        if (!fin) chk("load_timeout", 128'(0), 128'(1));

        if (ended_done) begin
            chk("idle_after_done", 128'({busy, done, config_en, byte_ready}), '0);
            chk("en_cycles", 128'(en_cnt), 128'(L));
            chk("bs_sequence", bs_vec, exp_vec);
            chk("handshakes", 128'(hs_cnt), 128'(nbytes));
            chk("reset_nn_pulses", 128'(rnn_cnt), 128'(1));
            chk("done_pulses", 128'(dn_cnt), 128'(1));
            chk("done_after_reset_nn", 128'(dn_cyc), 128'(rnn_cyc + 1));
            chk("ready_en_overlap", 128'(overlap), 128'(0));
            chk("accept_latency", 128'(lat_bad), 128'(0));
            for (int i = 0; i < L; i++) begin
                ob = mq.pop_front();
                mcrc = crc_upd(mcrc, ob);
                mq.push_back(exp_vec[i]);
            end
            if (mknown) chk("crc_readback", 128'(crc), 128'(mcrc));
            mknown = 1'b1;
            for (int i = 0; i < L; i++) mvec[L-1-i] = mq[i];
            chk("chain_contents", 128'(chain), mvec);
        end else if (aborted) begin
            chk("abort_idle", 128'({busy, config_en, byte_ready, reset_nn, done}), '0);
            chk("abort_shifts", 128'(en_cnt), 128'(abort_at));
            mask = (128'(1) << abort_at) - 128'(1);
            chk("abort_bits", bs_vec & mask, exp_vec & mask);
            chk("abort_no_pulses", 128'(rnn_cnt + dn_cnt), 128'(0));
            repeat (3) begin
                @(negedge clk);
                if (reset_nn || done || config_en || busy) quiet++;
            end
            chk("abort_quiet", 128'(quiet), 128'(0));
            for (int i = 0; i < abort_at; i++) begin
                ob = mq.pop_front();
                mq.push_back(exp_vec[i]);
            end
        end else if (reset_hit) begin
            repeat (3) begin
                @(negedge clk);
                if (reset_nn || done || config_en || busy) quiet++;
            end
            chk("arst_quiet", 128'(quiet + rnn_cnt), 128'(0));
            mknown = 1'b0;
        end
    endtask

    initial begin
        int en8, r8, d8, rc, dc;
        bit f8;
        logic [7:0] v8;

        rst_n = 1'b0; start = 1'b0; start8 = 1'b0; abort = 1'b0;
        byte_valid = 1'b0; byte_data = 8'h00;
        for (int i = 0; i < L; i++) mq.push_back(1'b1);
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'({byte_ready, config_en, bs_out, reset_nn, busy, done, crc}), '0);
        rst_n = 1'b1;
        @(negedge clk);

        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 128'({busy, byte_ready}), '0);

        for (int i = 0; i < 16; i++) lb[i] = 8'h00;
        run_load(9, -1, 0, 0);
        run_load(9, -1, 0, 0);
        chk("crc_second_zero", 128'(crc), 128'(0));

        for (int i = 0; i < 16; i++) lb[i] = 8'(i + 1);
        run_load(9, -1, 0, 0);
        saved = chain;
        run_load(9, 3, 0, 0);
        chk("stall_chain_same", 128'(chain), 128'(saved));

        repeat (3) begin
            for (int i = 0; i < 16; i++) lb[i] = 8'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run_load(9, -1, 0, 0);
        end

        for (int i = 0; i < 16; i++) lb[i] = 8'($urandom);
        run_load(9, -1, 20, 0);
        run_load(9, -1, 0, 0);

        run_load(9, -1, 0, 10);
        for (int i = 0; i < 16; i++) lb[i] = 8'($urandom);
        run_load(9, -1, 0, 0);
        run_load(9, -1, 0, 0);

        en8 = 0; r8 = 0; d8 = 0; rc = -1; dc = -2; f8 = 1'b0; v8 = 8'h00;
        byte_data = 8'hA5; byte_valid = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int cyc = 0; cyc < 60 && !f8; cyc++) begin
            if (config_en8) begin
                if (en8 < 8) v8[en8] = bs_out8;
                en8++;
            end
            if (reset_nn8) begin r8++; rc = cyc; end
            if (done8) begin d8++; dc = cyc; f8 = 1'b1; end
            @(negedge clk);
        end
        byte_valid = 1'b0;
        if (!f8) chk("len8_timeout", 128'(0), 128'(1));
        chk("len8_en_cycles", 128'(en8), 128'(8));
        chk("len8_bits", 128'(v8), 128'(8'hA5));
        chk("len8_reset_nn", 128'(r8), 128'(1));
        chk("len8_done", 128'(d8), 128'(1));
        chk("len8_order", 128'(dc), 128'(rc + 1));
        chk("len8_crc", 128'(crc8), 128'(0));
        chk("len8_idle", 128'({busy8, busy}), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
